modulo_controle_interrupcao: RTL and testbench
==============================================

Name: modulo_controle_interrupcao

Overview:
Generates the interrupt side of the PC/OS handshake. It drives `int_clk` and `halt`, and produces `pc_retorno_so` for the PC register.
- Tracks OS vs. user mode.
- Arms a preemption quantum when the OS executes `os_jump_to`.
- Records the interrupt cause and the user resume address, so the OS can reschedule the process.
- Sits beside the PC, fed by the instruction decoder and the PC's current/next addresses.

Parameters:
- ADDR_WIDTH, 13, instruction address width (matches the PC).
- QUANTUM_WIDTH, 16, width of the quantum register and down-counter.
- DEFAULT_QUANTUM, 1000, quantum loaded at reset.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- loop_enable  in  1  external run switch; 0 freezes all state, like the PC.
- instrucao  in  ADDR_WIDTH  current PC value.
- instrucao_modificada  in  ADDR_WIDTH  next PC computed by the datapath.
- os_jump_to  in  1  decoder strobe: OS is jumping into a user process.
- halt_req  in  1  decoder strobe: user process executed HALT.
- quantum_wr  in  1  write strobe for the quantum register.
- quantum_valor  in  QUANTUM_WIDTH  new quantum value.
- int_clk  out  1  timer interrupt pulse to the PC.
- halt  out  1  HALT interrupt pulse to the PC.
- pc_retorno_so  out  ADDR_WIDTH  OS address the PC returns to on interrupt.
- pc_salvo_usuario  out  ADDR_WIDTH  user resume address.
- causa_interrupcao  out  2  00 NONE, 01 TIMER, 10 HALT, 11 reserved.
- modo_usuario  out  1  1 while a user process owns the CPU.
- contador_quantum  out  QUANTUM_WIDTH  remaining quantum, for debug and the OS.

Behaviour:
- Reset (async, `reset_n`=0) forces these values immediately, including mid-pulse:
  - state ST_SO; `int_clk`=0, `halt`=0.
  - `pc_retorno_so`=0, `pc_salvo_usuario`=0, `causa_interrupcao`=00.
  - `modo_usuario`=0, `contador_quantum`=0, quantum register=DEFAULT_QUANTUM.
- `loop_enable`=0: no register changes. An asserted pulse stays high until enable returns, then completes its single enabled cycle. All rules below count enabled cycles only.
- All outputs are registered.
- FSM with 3 states:
  - ST_SO:
    - `quantum_wr` loads the quantum register.
    - `os_jump_to`=1 sets `pc_retorno_so` <= `instrucao`+1 (mod 2^ADDR_WIDTH), `contador_quantum` <= quantum register, `causa` <= NONE, `modo_usuario` <= 1, next ST_USUARIO.
    - If `quantum_wr` and `os_jump_to` occur together, the counter loads `quantum_valor` (new value wins).
    - `halt_req` is ignored.
  - ST_USUARIO:
    - `quantum_wr` and `os_jump_to` are ignored.
    - Priority 1: `halt_req`=1 sets `halt` <= 1 and `causa` <= HALT, next ST_INT.
    - Priority 2: quantum≠0 and `contador_quantum`==1 sets `contador_quantum` <= 0, `int_clk` <= 1, `causa` <= TIMER, next ST_INT.
    - Otherwise, if quantum≠0, the counter decrements.
    - Quantum==0 disables the timer: counter holds 0 and there is never an `int_clk`.
    - Simultaneous `halt_req` and expiry: HALT wins, `int_clk` stays 0.
  - ST_INT (exactly one enabled cycle):
    - Exactly one of `int_clk`/`halt` is high.
    - Sets `pc_salvo_usuario` <= `instrucao_modificada`. The instruction in this cycle completes and the user later resumes at its successor.
    - Next cycle clears both pulses, sets `modo_usuario` <= 0, next ST_SO.
- Timing for quantum N≥1 with `os_jump_to` in cycle T:
  - USUARIO occupies cycles T+1..T+N.
  - Interrupt pulse in cycle T+N+1.
  - Back in ST_SO at cycle T+N+2.
- `causa_interrupcao`, `pc_salvo_usuario` and `pc_retorno_so` persist until the next `os_jump_to` or reset.

Decomposition:
- Shared package holds:
  - state encodings ST_SO/ST_USUARIO/ST_INT;
  - cause codes CAUSA_NONE/TIMER/HALT;
  - DEFAULT_QUANTUM.
- One natural sub-module, `contador_quantum_dec`: loadable down-counter with enable and an "is-one" flag, parameterised by QUANTUM_WIDTH.

Test Plan:
1. Reset, then quantum_wr=1 with quantum_valor=3; os_jump_to with instrucao=100 -> pc_retorno_so=101 and modo_usuario=1 at T+1; int_clk=1 only at T+4 with causa=01; pc_salvo_usuario = instrucao_modificada sampled at T+4; modo_usuario=0 at T+5.
2. Quantum 10, halt_req at the 2nd user cycle with instrucao_modificada=0x0205 -> halt=1 next cycle, int_clk=0, causa=10, pc_salvo_usuario=0x0205.
3. Quantum 1 with halt_req on the first user cycle -> halt pulse only, causa=10, no int_clk ever.
4. Quantum 4, drop loop_enable for 7 cycles mid-quantum and again during the int_clk pulse -> counter frozen; int_clk stays high while frozen and clears one enabled cycle after re-enable; total enabled user cycles = 4.
5. Quantum 0, run 2000 cycles in user mode -> no int_clk; contador_quantum=0. Also os_jump_to at instrucao=0x1FFF -> pc_retorno_so=0x0000 (wrap).
6. Assert reset_n=0 asynchronously mid-pulse -> int_clk/halt drop immediately; all outputs take their reset values; quantum returns to 1000.

Source files
------------

// File: rtl/modulo_controle_interrupcao_pkg.sv
// Shared types and constants for the interrupt controller that sits beside the PC.
// FSM encodings, interrupt cause codes and the reset-time quantum.
package modulo_controle_interrupcao_pkg;

  typedef enum logic [1:0] {
    ST_SO      = 2'd0,
    ST_USUARIO = 2'd1,
    ST_INT     = 2'd2
  } estado_t;

  localparam logic [1:0] CAUSA_NONE  = 2'b00;
  localparam logic [1:0] CAUSA_TIMER = 2'b01;
  localparam logic [1:0] CAUSA_HALT  = 2'b10;

  localparam int unsigned DEFAULT_QUANTUM = 1000;

endpackage

// File: rtl/modulo_controle_interrupcao_if.sv
// Signal bundle between the decoder/PC side (master) and the interrupt controller (slave).
// Strobes are one-cycle qualifiers sampled on the rising clock edge only while
// loop_enable=1; there is no ready: the controller accepts every qualified strobe.
interface modulo_controle_interrupcao_if #(
  parameter int ADDR_WIDTH    = 13,
  parameter int QUANTUM_WIDTH = 16
);
  import modulo_controle_interrupcao_pkg::*;

  logic                     loop_enable;
  logic [ADDR_WIDTH-1:0]    instrucao;
  logic [ADDR_WIDTH-1:0]    instrucao_modificada;
  logic                     os_jump_to;
  logic                     halt_req;
  logic                     quantum_wr;
  logic [QUANTUM_WIDTH-1:0] quantum_valor;

  logic                     int_clk;
  logic                     halt;
  logic [ADDR_WIDTH-1:0]    pc_retorno_so;
  logic [ADDR_WIDTH-1:0]    pc_salvo_usuario;
  logic [1:0]               causa_interrupcao;
  logic                     modo_usuario;
  logic [QUANTUM_WIDTH-1:0] contador_quantum;
  estado_t                  estado;

  modport master (
    output loop_enable, instrucao, instrucao_modificada, os_jump_to, halt_req,
           quantum_wr, quantum_valor,
    input  int_clk, halt, pc_retorno_so, pc_salvo_usuario, causa_interrupcao,
           modo_usuario, contador_quantum, estado
  );

  modport slave (
    input  loop_enable, instrucao, instrucao_modificada, os_jump_to, halt_req,
           quantum_wr, quantum_valor,
    output int_clk, halt, pc_retorno_so, pc_salvo_usuario, causa_interrupcao,
           modo_usuario, contador_quantum, estado
  );

endinterface

// File: rtl/modulo_controle_interrupcao_contador_quantum_dec.sv
// Loadable down-counter for the preemption quantum, with a global enable and an is-one flag.
// Load has priority over clear, which has priority over decrement.
module contador_quantum_dec #(
  parameter int QUANTUM_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     load,
  input  logic [QUANTUM_WIDTH-1:0] load_val,
  input  logic                     clr,
  input  logic                     dec,
  output logic [QUANTUM_WIDTH-1:0] count,
  output logic                     is_one
);

  logic [QUANTUM_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)                                  count_d = load_val;
    else if (clr)                              count_d = '0;
    else if (dec && (count_q != '0))           count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  count_q <= '0;
    else if (en)   count_q <= count_d;
  end

  assign count  = count_q;
  assign is_one = (count_q == QUANTUM_WIDTH'(1));

endmodule

// File: rtl/modulo_controle_interrupcao.sv
// Interrupt side of the PC/OS handshake: tracks OS/user mode, runs the preemption quantum,
// raises int_clk/halt for one enabled cycle and records cause and user resume address.
module modulo_controle_interrupcao
  import modulo_controle_interrupcao_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 13,
  parameter int          QUANTUM_WIDTH   = 16,
  parameter int unsigned DEFAULT_QUANTUM = modulo_controle_interrupcao_pkg::DEFAULT_QUANTUM
) (
  input  logic                       clock,
  input  logic                       reset_n,
  modulo_controle_interrupcao_if.slave bus
);

  estado_t                  estado_q, estado_d;
  logic                     int_clk_q, int_clk_d;
  logic                     halt_q, halt_d;
  logic [ADDR_WIDTH-1:0]    pc_retorno_q, pc_retorno_d;
  logic [ADDR_WIDTH-1:0]    pc_salvo_q, pc_salvo_d;
  logic [1:0]               causa_q, causa_d;
  logic                     modo_q, modo_d;
  logic [QUANTUM_WIDTH-1:0] quantum_q, quantum_d;

  logic                     cnt_load, cnt_clr, cnt_dec, cnt_is_one;
  logic [QUANTUM_WIDTH-1:0] cnt_load_val, cnt_value;
  logic                     timer_on;

  // A zero quantum disables preemption entirely.
  assign timer_on = (quantum_q != '0);

  always_comb begin
    estado_d     = estado_q;
    int_clk_d    = int_clk_q;
    halt_d       = halt_q;
    pc_retorno_d = pc_retorno_q;
    pc_salvo_d   = pc_salvo_q;
    causa_d      = causa_q;
    modo_d       = modo_q;
    quantum_d    = quantum_q;
    cnt_load     = 1'b0;
    cnt_load_val = quantum_q;
    cnt_clr      = 1'b0;
    cnt_dec      = 1'b0;

    case (estado_q)
      ST_SO: begin
        if (bus.quantum_wr) quantum_d = bus.quantum_valor;
        if (bus.os_jump_to) begin
          pc_retorno_d = bus.instrucao + 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = bus.quantum_wr ? bus.quantum_valor : quantum_q;
          causa_d      = CAUSA_NONE;
          modo_d       = 1'b1;
          estado_d     = ST_USUARIO;
        end
      end
      ST_USUARIO: begin
        // HALT outranks a quantum expiring in the same cycle.
        if (bus.halt_req) begin
          halt_d   = 1'b1;
          causa_d  = CAUSA_HALT;
          estado_d = ST_INT;
        end else if (timer_on && cnt_is_one) begin
          cnt_clr   = 1'b1;
          int_clk_d = 1'b1;
          causa_d   = CAUSA_TIMER;
          estado_d  = ST_INT;
        end else if (timer_on) begin
          cnt_dec = 1'b1;
        end
      end
      ST_INT: begin
        // The instruction in this cycle retires; the user resumes at its successor.
        pc_salvo_d = bus.instrucao_modificada;
        int_clk_d  = 1'b0;
        halt_d     = 1'b0;
        modo_d     = 1'b0;
        estado_d   = ST_SO;
      end
      default: estado_d = ST_SO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q     <= ST_SO;
      int_clk_q    <= 1'b0;
      halt_q       <= 1'b0;
      pc_retorno_q <= '0;
      pc_salvo_q   <= '0;
      causa_q      <= CAUSA_NONE;
      modo_q       <= 1'b0;
      quantum_q    <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
    end else if (bus.loop_enable) begin
      estado_q     <= estado_d;
      int_clk_q    <= int_clk_d;
      halt_q       <= halt_d;
      pc_retorno_q <= pc_retorno_d;
      pc_salvo_q   <= pc_salvo_d;
      causa_q      <= causa_d;
      modo_q       <= modo_d;
      quantum_q    <= quantum_d;
    end
  end

  contador_quantum_dec #(.QUANTUM_WIDTH(QUANTUM_WIDTH)) u_contador (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (bus.loop_enable),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .clr      (cnt_clr),
    .dec      (cnt_dec),
    .count    (cnt_value),
    .is_one   (cnt_is_one)
  );

  assign bus.int_clk           = int_clk_q;
  assign bus.halt              = halt_q;
  assign bus.pc_retorno_so     = pc_retorno_q;
  assign bus.pc_salvo_usuario  = pc_salvo_q;
  assign bus.causa_interrupcao = causa_q;
  assign bus.modo_usuario      = modo_q;
  assign bus.contador_quantum  = cnt_value;
  assign bus.estado            = estado_q;

endmodule

// File: tb/tb_modulo_controle_interrupcao.sv
// Bench for modulo_controle_interrupcao: directed scenarios plus random traffic, all
// outputs compared every cycle against a behavioural model of the OS/user protocol.
module tb_modulo_controle_interrupcao;
  import modulo_controle_interrupcao_pkg::*;

  localparam int AW = 13;
  localparam int QW = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  modulo_controle_interrupcao_if #(.ADDR_WIDTH(AW), .QUANTUM_WIDTH(QW)) bus ();

  modulo_controle_interrupcao #(.ADDR_WIDTH(AW), .QUANTUM_WIDTH(QW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_user: a process owns the CPU; m_pulse: 0 none, 1 timer, 2 halt pending this cycle;
  // m_rem: quantum cycles the process still has left.
  int   m_quantum, m_rem, m_ret, m_saved, m_cause, m_pulse;
  bit   m_user;
  logic [1:0] exp_q[$];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_quantum <= 1000; m_rem <= 0; m_ret <= 0; m_saved <= 0;
      m_cause <= 0; m_pulse <= 0; m_user <= 1'b0;
      exp_q.delete();
    end else if (bus.loop_enable) begin
      if (m_pulse != 0) begin
        m_saved <= int'(bus.instrucao_modificada);
        m_pulse <= 0;
        m_user  <= 1'b0;
      end else if (!m_user) begin
        if (bus.quantum_wr) m_quantum <= int'(bus.quantum_valor);
        if (bus.os_jump_to) begin
          m_ret   <= (int'(bus.instrucao) + 1) % (1 << AW);
          m_rem   <= bus.quantum_wr ? int'(bus.quantum_valor) : m_quantum;
          m_cause <= 0;
          m_user  <= 1'b1;
        end
      end else if (bus.halt_req) begin
        m_pulse <= 2; m_cause <= 2;
        exp_q.push_back(2'b10);
      end else if (m_quantum != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_pulse <= 1; m_cause <= 1;
          exp_q.push_back(2'b01);
        end
      end
    end
  end

  // Enabled cycles spent in user state, for the quantum-length check.
  int user_cyc = 0;
  always @(posedge clock)
    if (reset_n && bus.loop_enable && bus.estado == ST_USUARIO) user_cyc++;

  // ---------------- scoreboard ----------------
  bit prev_pulse = 1'b0;
  int n_int_rise = 0;

  task automatic check_outputs();
    logic cur;
    check_val("int_clk",  32'(bus.int_clk),           32'(m_pulse == 1));
    check_val("halt",     32'(bus.halt),              32'(m_pulse == 2));
    check_val("modo",     32'(bus.modo_usuario),      32'(m_user));
    check_val("contador", 32'(bus.contador_quantum),  32'(m_rem));
    check_val("pc_ret",   32'(bus.pc_retorno_so),     32'(m_ret));
    check_val("pc_salvo", 32'(bus.pc_salvo_usuario),  32'(m_saved));
    check_val("causa",    32'(bus.causa_interrupcao), 32'(m_cause));
    cur = bus.int_clk | bus.halt;
    if (cur && !prev_pulse) begin
      if (bus.int_clk) n_int_rise++;
      if (exp_q.size() == 0) check_val("pulse_unexpected", 32'(1), 32'(0));
      else check_val("pulse_cause", 32'(bus.causa_interrupcao), 32'(exp_q.pop_front()));
    end
    prev_pulse = cur;
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(negedge clock);
    check_outputs();
    bus.os_jump_to           = 1'b0;
    bus.halt_req             = 1'b0;
    bus.quantum_wr           = 1'b0;
    bus.quantum_valor        = QW'($urandom_range(0, 20));
    bus.instrucao            = AW'($urandom);
    bus.instrucao_modificada = AW'($urandom);
  endtask

  task automatic to_so();
    for (int i = 0; i < 50; i++) begin
      if (!bus.modo_usuario && !bus.int_clk && !bus.halt) return;
      bus.halt_req = 1'b1;
      step();
    end
    check_val("to_so_timeout", 32'(1), 32'(0));
  endtask

  int  r0;
  bit  seen;
  logic [AW-1:0] saved_exp;

  initial begin
    reset_n = 1'b0;
    bus.loop_enable = 1'b1;
    bus.os_jump_to = 1'b0; bus.halt_req = 1'b0; bus.quantum_wr = 1'b0;
    bus.quantum_valor = '0; bus.instrucao = '0; bus.instrucao_modificada = '0;
    repeat (2) @(negedge clock);
    check_val("rst_int_clk",  32'(bus.int_clk), 32'(0));
    check_val("rst_modo",     32'(bus.modo_usuario), 32'(0));
    check_val("rst_contador", 32'(bus.contador_quantum), 32'(0));
    check_val("rst_causa",    32'(bus.causa_interrupcao), 32'(0));
    reset_n = 1'b1;
    step();

    // 1: quantum 3, timer expiry
    bus.quantum_wr = 1'b1; bus.quantum_valor = 16'd3;
    step();
    bus.os_jump_to = 1'b1; bus.instrucao = 13'd100;
    step();                                                  // T+1
    check_val("t1_ret",  32'(bus.pc_retorno_so), 32'(101));
    check_val("t1_modo", 32'(bus.modo_usuario), 32'(1));
    step(); step();                                          // T+3
    check_val("t1_no_int_early", 32'(bus.int_clk), 32'(0));
    step();                                                  // T+4
    check_val("t1_int",   32'(bus.int_clk), 32'(1));
    check_val("t1_causa", 32'(bus.causa_interrupcao), 32'(1));
    saved_exp = bus.instrucao_modificada;
    step();                                                  // T+5
    check_val("t1_salvo", 32'(bus.pc_salvo_usuario), 32'(saved_exp));
    check_val("t1_modo0", 32'(bus.modo_usuario), 32'(0));
    check_val("t1_int0",  32'(bus.int_clk), 32'(0));

    // 2: quantum 10 (written together with the jump), HALT on 2nd user cycle
    to_so();
    bus.quantum_wr = 1'b1; bus.quantum_valor = 16'd10; bus.os_jump_to = 1'b1;
    step();
    check_val("t2_cnt", 32'(bus.contador_quantum), 32'(10));
    step();
    bus.halt_req = 1'b1;
    step();
    check_val("t2_halt",  32'(bus.halt), 32'(1));
    check_val("t2_int",   32'(bus.int_clk), 32'(0));
    check_val("t2_causa", 32'(bus.causa_interrupcao), 32'(2));
    bus.instrucao_modificada = 13'h0205;
    step();
    check_val("t2_salvo", 32'(bus.pc_salvo_usuario), 32'h0205);

    // 3: quantum 1, HALT coincides with expiry
    to_so();
    bus.quantum_wr = 1'b1; bus.quantum_valor = 16'd1; bus.os_jump_to = 1'b1;
    step();
    r0 = n_int_rise;
    bus.halt_req = 1'b1;
    step();
    check_val("t3_halt",  32'(bus.halt), 32'(1));
    check_val("t3_int",   32'(bus.int_clk), 32'(0));
    check_val("t3_causa", 32'(bus.causa_interrupcao), 32'(2));
    repeat (5) step();
    check_val("t3_no_int", 32'(n_int_rise), 32'(r0));

    // 4: quantum 4 with freezes mid-quantum and during the pulse
    to_so();
    bus.quantum_wr = 1'b1; bus.quantum_valor = 16'd4; bus.os_jump_to = 1'b1;
    user_cyc = 0;
    step(); step();
    bus.loop_enable = 1'b0;
    repeat (7) step();
    check_val("t4_frozen_cnt", 32'(bus.contador_quantum), 32'(3));
    bus.loop_enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = bus.int_clk;
    end
    check_val("t4_int_seen",  32'(seen), 32'(1));
    check_val("t4_user_cyc",  32'(user_cyc), 32'(4));
    bus.loop_enable = 1'b0;
    repeat (7) begin
      step();
      check_val("t4_int_hold", 32'(bus.int_clk), 32'(1));
    end
    bus.loop_enable = 1'b1;
    step();
    check_val("t4_int_clear", 32'(bus.int_clk), 32'(0));

    // 5: quantum 0 disables the timer; return address wraps
    to_so();
    bus.quantum_wr = 1'b1; bus.quantum_valor = 16'd0;
    bus.os_jump_to = 1'b1; bus.instrucao = 13'h1FFF;
    step();
    check_val("t5_wrap", 32'(bus.pc_retorno_so), 32'(0));
    r0 = n_int_rise;
    repeat (2000) step();
    check_val("t5_no_int", 32'(n_int_rise), 32'(r0));
    check_val("t5_cnt0",   32'(bus.contador_quantum), 32'(0));
    check_val("t5_modo",   32'(bus.modo_usuario), 32'(1));

    // random traffic
    to_so();
    for (int i = 0; i < 600; i++) begin
      step();
      bus.loop_enable   = ($urandom_range(0, 9) != 0);
      bus.quantum_wr    = ($urandom_range(0, 5) == 0);
      bus.quantum_valor = QW'($urandom_range(0, 6));
      bus.os_jump_to    = ($urandom_range(0, 3) == 0);
      bus.halt_req      = ($urandom_range(0, 15) == 0);
    end
    bus.loop_enable = 1'b1;
    step();

    // 6: asynchronous reset in the middle of an int_clk pulse
    to_so();
    bus.quantum_wr = 1'b1; bus.quantum_valor = 16'd2; bus.os_jump_to = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = bus.int_clk;
    end
    check_val("t6_int_seen", 32'(seen), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    check_val("t6_int0",   32'(bus.int_clk), 32'(0));
    check_val("t6_halt0",  32'(bus.halt), 32'(0));
    check_val("t6_ret0",   32'(bus.pc_retorno_so), 32'(0));
    check_val("t6_salvo0", 32'(bus.pc_salvo_usuario), 32'(0));
    check_val("t6_causa0", 32'(bus.causa_interrupcao), 32'(0));
    check_val("t6_modo0",  32'(bus.modo_usuario), 32'(0));
    check_val("t6_cnt0",   32'(bus.contador_quantum), 32'(0));
    check_outputs();
    step();
    reset_n = 1'b1;
    step();
    bus.os_jump_to = 1'b1;
    step();
    check_val("t6_default_quantum", 32'(bus.contador_quantum), 32'(1000));
    step();

    check_val("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
